player_plot_scheduler: RTL and testbench

//  Time-multiplexes N player positions onto the single VGA adapter write port (x, y, colour, plot).

---
 rtl/tron_pkg.sv | 17 +
 rtl/clear_sweeper.sv | 50 +++++
 rtl/player_plot_scheduler.sv | 130 +++++++++++++
 tb/tb_player_plot_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - shared screen extents, scheduler states and default palette for DE2Tron
package tron_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic {
    S_SCAN  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] P3 = 3'b100;
  localparam logic [2:0] P4 = 3'b110;

endpackage

// File: rtl/clear_sweeper.sv
// rtl/clear_sweeper.sv - raster x/y counter for the full-screen clear sweep
module clear_sweeper
  import tron_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = tron_pkg::SCREEN_W,
  parameter int SCREEN_H = tron_pkg::SCREEN_H
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           start,
  output logic [X_W-1:0] sx,
  output logic [Y_W-1:0] sy,
  output logic           busy,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  logic at_end;

  assign at_end = (sx == X_MAX) && (sy == Y_MAX);
  // sx/sy is the pixel being handed out this cycle; it rests at (0,0) when idle
  assign last   = at_end && (start || busy);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sx   <= '0;
      sy   <= '0;
      busy <= 1'b0;
    end else if (start || busy) begin
      if (at_end) begin
        sx   <= '0;
        sy   <= '0;
        busy <= 1'b0;
      end else begin
        busy <= 1'b1;
        if (sx == X_MAX) begin
          sx <= '0;
          sy <= sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/player_plot_scheduler.sv
// rtl/player_plot_scheduler.sv - round-robin player plot scheduler with clear sweep for vga_adapter
module player_plot_scheduler
  import tron_pkg::*;
#(
  parameter int NUM_PLAYERS    = 4,
  parameter int X_W            = 8,
  parameter int Y_W            = 7,
  parameter int COLOUR_W       = 3,
  parameter int SCREEN_W       = tron_pkg::SCREEN_W,
  parameter int SCREEN_H       = tron_pkg::SCREEN_H,
  parameter int SKIP_UNCHANGED = 1
) (
  input  logic                               CLOCK_50,
  input  logic                               resetn,
  input  logic                               enable,
  input  logic [NUM_PLAYERS-1:0]             active,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]   pos,
  input  logic [NUM_PLAYERS*COLOUR_W-1:0]    pal,
  input  logic [COLOUR_W-1:0]                bg_colour,
  input  logic                               clear_req,
  output logic [X_W-1:0]                     x,
  output logic [Y_W-1:0]                     y,
  output logic [COLOUR_W-1:0]                colour,
  output logic                               plot,
  output logic                               clear_busy,
  output logic                               clear_done
);

  localparam int PW    = X_W + Y_W;
  localparam int PTR_W = $clog2(NUM_PLAYERS);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_PLAYERS - 1);

  logic [PW-1:0]       pos_a    [NUM_PLAYERS];
  logic [COLOUR_W-1:0] pal_a    [NUM_PLAYERS];
  logic [PW-1:0]       last_pos [NUM_PLAYERS];

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic             sweep_final;
  logic             sweep_start;
  logic             hit;
  logic [X_W-1:0]   sx;
  logic [Y_W-1:0]   sy;
  logic             sweep_busy;
  logic             sweep_last;

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pos_a[i] = pos[i*PW +: PW];
      pal_a[i] = pal[i*COLOUR_W +: COLOUR_W];
    end
  end

  assign sweep_start = (state == S_SCAN) && clear_req;
  assign hit = active[ptr] && ((SKIP_UNCHANGED == 0) || (pos_a[ptr] != last_pos[ptr]));

  clear_sweeper #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweeper (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (sweep_start),
    .sx       (sx),
    .sy       (sy),
    .busy     (sweep_busy),
    .last     (sweep_last)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= S_SCAN;
      ptr         <= '0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      sweep_final <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) last_pos[i] <= '1;
    end else begin
      plot       <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        S_SCAN: begin
          // a clear request pre-empts this cycle's slot visit
          if (clear_req) begin
            state       <= S_CLEAR;
            plot        <= 1'b1;
            x           <= sx;
            y           <= sy;
            colour      <= bg_colour;
            clear_busy  <= 1'b1;
            sweep_final <= sweep_last;
          end else if (enable) begin
            ptr <= (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
            if (hit) begin
              plot          <= 1'b1;
              {x, y}        <= pos_a[ptr];
              colour        <= pal_a[ptr];
              last_pos[ptr] <= pos_a[ptr];
            end
          end
        end
        S_CLEAR: begin
          if (sweep_final) begin
            state       <= S_SCAN;
            ptr         <= '0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b1;
            sweep_final <= 1'b0;
            // forget every position so all active players repaint over the cleared screen
            for (int i = 0; i < NUM_PLAYERS; i++) last_pos[i] <= '1;
          end else if (sweep_busy) begin
            plot        <= 1'b1;
            x           <= sx;
            y           <= sy;
            colour      <= bg_colour;
            sweep_final <= sweep_last;
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_player_plot_scheduler.sv
// tb/tb_player_plot_scheduler.sv - scoreboard bench for player_plot_scheduler
module tb_player_plot_scheduler;
  import tron_pkg::*;

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
    bit busy;
  } exp_t;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        enable0 = 1'b0;
  logic        clear_req = 1'b0;
  logic [3:0]  active = 4'b0000;
  logic [59:0] pos = '0;
  logic [11:0] pal = '0;
  logic [2:0]  bg_colour = 3'b000;

  logic [7:0] x, x0;
  logic [6:0] y, y0;
  logic [2:0] colour, colour0;
  logic       plot, plot0, clear_busy, busy0, clear_done, done0;

  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  bit   expect_zero = 1'b0;
  bit   final_chk = 1'b0;
  exp_t q[$];
  exp_t q0[$];
  int   done_q[$];
  exp_t me;
  int   md;

  int         px[4];
  int         py[4];
  logic [2:0] pc[4];

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  player_plot_scheduler dut (
    .CLOCK_50 (CLOCK_50), .resetn (resetn), .enable (enable), .active (active),
    .pos (pos), .pal (pal), .bg_colour (bg_colour), .clear_req (clear_req),
    .x (x), .y (y), .colour (colour), .plot (plot),
    .clear_busy (clear_busy), .clear_done (clear_done)
  );

  player_plot_scheduler #(.SKIP_UNCHANGED(0)) dut0 (
    .CLOCK_50 (CLOCK_50), .resetn (resetn), .enable (enable0), .active (active),
    .pos (pos), .pal (pal), .bg_colour (bg_colour), .clear_req (1'b0),
    .x (x0), .y (y0), .colour (colour0), .plot (plot0),
    .clear_busy (busy0), .clear_done (done0)
  );

  // Monitor: pops the scoreboard whenever either DUT presents an output
  always @(negedge CLOCK_50) begin
    if (expect_zero) begin
      tests++;
      if ({x, y, colour, plot, clear_busy, clear_done} != '0) begin
        failed++;
        $display("FAIL reset_outputs cyc=%0d got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0",
                 cyc, x, y, colour, plot, clear_busy, clear_done);
      end
    end
    if (plot) begin
      tests++;
      if (q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_plot cyc=%0d got x=%0d y=%0d c=%0d want no plot", cyc, x, y, colour);
      end else begin
        me = q.pop_front();
        if (me.cyc != cyc || int'(x) != me.x || int'(y) != me.y || int'(colour) != me.c ||
            clear_busy !== me.busy) begin
          failed++;
          $display("FAIL plot got cyc=%0d x=%0d y=%0d c=%0d busy=%b want cyc=%0d x=%0d y=%0d c=%0d busy=%b",
                   cyc, x, y, colour, clear_busy, me.cyc, me.x, me.y, me.c, me.busy);
        end
      end
    end else if (clear_busy) begin
      tests++;
      failed++;
      $display("FAIL busy_without_plot cyc=%0d got busy=1 plot=0 want busy only with sweep pixels", cyc);
    end
    if (clear_done) begin
      tests++;
      if (done_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_done cyc=%0d got clear_done=1 want 0", cyc);
      end else begin
        md = done_q.pop_front();
        if (md != cyc || plot || clear_busy) begin
          failed++;
          $display("FAIL clear_done got cyc=%0d plot=%b busy=%b want cyc=%0d plot=0 busy=0",
                   cyc, plot, clear_busy, md);
        end
      end
    end
    if (plot0) begin
      tests++;
      if (q0.size() == 0) begin
        failed++;
        $display("FAIL unexpected_plot0 cyc=%0d got x=%0d y=%0d c=%0d want no plot", cyc, x0, y0, colour0);
      end else begin
        me = q0.pop_front();
        if (me.cyc != cyc || int'(x0) != me.x || int'(y0) != me.y || int'(colour0) != me.c) begin
          failed++;
          $display("FAIL plot0 got cyc=%0d x=%0d y=%0d c=%0d want cyc=%0d x=%0d y=%0d c=%0d",
                   cyc, x0, y0, colour0, me.cyc, me.x, me.y, me.c);
        end
      end
    end
    if (busy0 || done0) begin
      tests++;
      failed++;
      $display("FAIL dut0_clear cyc=%0d got busy=%b done=%b want 0 0", cyc, busy0, done0);
    end
    if (final_chk) begin
      tests++;
      if (q.size() != 0 || q0.size() != 0 || done_q.size() != 0) begin
        failed++;
        $display("FAIL leftover got plots=%0d plots0=%0d dones=%0d want 0 0 0", q.size(), q0.size(), done_q.size());
      end
    end
  end

  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic push(input bit which, input int k, input int xx, input int yy, input int cc, input bit b);
    exp_t e;
    e.cyc = k; e.x = xx; e.y = yy; e.c = cc; e.busy = b;
    if (which) q0.push_back(e);
    else q.push_back(e);
  endtask

  task automatic set_pos(input int i, input int xx, input int yy);
    px[i] = xx;
    py[i] = yy;
    pos[i*15 +: 15] = {xx[7:0], yy[6:0]};
  endtask

  task automatic expect_players(input int base);
    for (int i = 0; i < 4; i++) push(1'b0, base + i, px[i], py[i], int'(pc[i]), 1'b0);
  endtask

  task automatic expect_sweep(input int c, input int npix, input int bg);
    for (int n = 0; n < npix; n++) push(1'b0, c + 1 + n, n % 160, n / 160, bg, 1'b1);
  endtask

  initial begin
    int c;
    int base;
    int k;
    pc[0] = P1; pc[1] = P2; pc[2] = P3; pc[3] = P4;
    pal = {P4, P3, P2, P1};
    set_pos(0, 10, 20);
    set_pos(1, 30, 40);
    set_pos(2, 50, 60);
    set_pos(3, 70, 80);
    active = 4'b1111;
    @(posedge CLOCK_50);
    #1;
    expect_zero = 1'b1;
    wait_to(3);
    expect_zero = 1'b0;

    // first visits after reset plot every player once
    c = cyc;
    resetn = 1'b1;
    enable = 1'b1;
    base = c + 1;
    expect_players(base);
    wait_to(c + 20);

    // only P3 moves
    c = cyc;
    set_pos(2, 51, 60);
    k = c + 1;
    while ((k - base) % 4 != 2) k++;
    push(1'b0, k, 51, 60, int'(P3), 1'b0);
    wait_to(c + 12);

    // plot-every-visit instance with two active players
    c = cyc;
    active = 4'b0101;
    enable0 = 1'b1;
    for (int j = 0; j < 8; j += 2) push(1'b1, c + 1 + j, px[j % 4], py[j % 4], int'(pc[j % 4]), 1'b0);
    wait_to(c + 8);
    enable0 = 1'b0;
    wait_to(c + 12);
    active = 4'b1111;

    // full clear sweep then re-plot
    c = cyc;
    bg_colour = 3'b000;
    clear_req = 1'b1;
    expect_sweep(c, 19200, 0);
    done_q.push_back(c + 19201);
    expect_players(c + 19202);
    wait_to(c + 1);
    clear_req = 1'b0;
    wait_to(c + 19210);

    // second request mid-sweep is ignored
    c = cyc;
    bg_colour = 3'b101;
    clear_req = 1'b1;
    expect_sweep(c, 19200, 5);
    done_q.push_back(c + 19201);
    expect_players(c + 19202);
    wait_to(c + 1);
    clear_req = 1'b0;
    wait_to(c + 5001);
    clear_req = 1'b1;
    wait_to(c + 5002);
    clear_req = 1'b0;
    wait_to(c + 19210);

    // reset aborts a sweep without clear_done
    c = cyc;
    bg_colour = 3'b011;
    clear_req = 1'b1;
    expect_sweep(c, 100, 3);
    wait_to(c + 1);
    clear_req = 1'b0;
    wait_to(c + 101);
    resetn = 1'b0;
    expect_zero = 1'b1;
    wait_to(c + 104);
    expect_zero = 1'b0;
    c = cyc;
    resetn = 1'b1;
    expect_players(c + 1);
    wait_to(c + 12);

    final_chk = 1'b1;
    wait_to(cyc + 1);
    final_chk = 1'b0;
    wait_to(cyc + 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1400000;
    $display("FAIL watchdog cyc=%0d got no end of run want finish before limit", cyc);
    $fatal(1);
  end

endmodule
